// File: rtl/md_pkg.sv
// md_pkg - shared definitions for the multiply/divide issue controller.
// Holds the MD op-code constants, the default unit latencies, the timer
// width and the controller state encoding, plus small op-class helpers.
package md_pkg;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    // Wide enough for any latency the unit could plausibly need.
    localparam int CNT_W = 16;

    localparam logic [3:0] OP_NONE      = 4'd0;
    localparam logic [3:0] OP_MUL_FIRST = 4'd1;
    localparam logic [3:0] OP_MUL_LAST  = 4'd6;
    localparam logic [3:0] OP_MTHI      = 4'd7;
    localparam logic [3:0] OP_MTLO      = 4'd8;
    localparam logic [3:0] OP_MFHI      = 4'd9;
    localparam logic [3:0] OP_MFLO      = 4'd10;
    localparam logic [3:0] OP_DIV       = 4'd14;
    localparam logic [3:0] OP_DIVU      = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdState_t;

    function automatic logic isMulOp(input logic [3:0] op);
        return (op >= OP_MUL_FIRST) && (op <= OP_MUL_LAST);
    endfunction

    function automatic logic isDivOp(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic isMfOp(input logic [3:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

    // Codes 0 and 11-13 are not MD instructions and are ignored.
    function automatic logic isMdOp(input logic [3:0] op);
        return isMulOp(op) || isDivOp(op) || (op >= OP_MTHI && op <= OP_MFLO);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer - down-counter tracking how many busy cycles remain for the
// operation in flight in the MD unit.
// Ports:
//   Clk, Rst      clock and synchronous active-high reset (clears the count)
//   LoadVal_i     latency loaded when an operation starts
//   Load_i        load strobe (takes priority over decrement)
//   Dec_i         decrement enable, held while the controller is busy
//   Zero_o        the count reaches zero on the coming edge
module md_busy_timer
    import md_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic [CNT_W-1:0] LoadVal_i,
    input  logic             Load_i,
    input  logic             Dec_i,
    output logic             Zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else if (Load_i) begin
            cnt_q <= LoadVal_i;
        end else if (Dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Looking one step ahead lets the FSM leave its busy state on the same
    // edge the count goes 1->0; a count already at zero also releases it so
    // a zero latency can never lock the controller up.
    assign Zero_o = Dec_i && (cnt_q < CNT_W'(2));

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl - issue controller sitting between the pipeline and the
// multiply/divide unit. Accepts MD-class requests in the same cycle when the
// unit is idle, starts multiplies and divides, stalls the pipeline while an
// operation is in flight and counts stall cycles.
// Ports:
//   Clk, Rst            clock and synchronous active-high reset (shared with the MD unit)
//   ReqValid/ReqOp      MD request from the pipeline and its op code
//   ReqA/ReqB           rs/rt operands
//   Flush               squash the presented request
//   MdOp/MdStart        op code and one-cycle start pulse to the MD unit
//   MdA/MdB             operands to the MD unit (always pass-through)
//   Stall               freeze the issuing stage
//   Busy                multiply/divide in flight
//   MfValid             MFHI/MFLO accepted, unit result valid this cycle
//   StallCnt            saturating count of stall cycles
module md_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    input  logic [3:0]  ReqOp,
    input  logic [31:0] ReqA,
    input  logic [31:0] ReqB,
    input  logic        Flush,
    output logic [3:0]  MdOp,
    output logic        MdStart,
    output logic [31:0] MdA,
    output logic [31:0] MdB,
    output logic        Stall,
    output logic        Busy,
    output logic        MfValid,
    output logic [15:0] StallCnt
);

    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);

    mdState_t    state_q;
    logic        busy_q;
    logic [15:0] stallCnt_q;
    logic [15:0] stallCnt_d;

    logic reqOk;
    logic isIdle;
    logic accept;
    logic startMul;
    logic startDiv;
    logic timerZero;

    // Reset masks the request so every pipeline-facing output is quiet
    // while Rst is high, whatever state the registers hold.
    assign reqOk    = ReqValid && !Flush && !Rst && isMdOp(ReqOp);
    assign isIdle   = (state_q == ST_IDLE);
    assign accept   = reqOk && isIdle;
    assign startMul = accept && isMulOp(ReqOp);
    // A divide by zero is accepted but never started, so HI/LO keep their value.
    assign startDiv = accept && isDivOp(ReqOp) && (ReqB != 32'd0);

    assign MdOp     = accept ? ReqOp : OP_NONE;
    assign MdStart  = startMul || startDiv;
    assign MfValid  = accept && isMfOp(ReqOp);
    assign Stall    = reqOk && !isIdle;
    assign MdA      = ReqA;
    assign MdB      = ReqB;
    assign Busy     = busy_q;
    assign StallCnt = stallCnt_q;

    md_busy_timer u_timer (
        .Clk       (Clk),
        .Rst       (Rst),
        .LoadVal_i (startMul ? MUL_LAT_C : DIV_LAT_C),
        .Load_i    (MdStart),
        .Dec_i     (!isIdle),
        .Zero_o    (timerZero)
    );

    // Busy is registered next to the state so it is a clean flop output.
    // Flush never touches an operation already in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startMul) begin
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                    end else if (startDiv) begin
                        state_q <= ST_DIV;
                        busy_q  <= 1'b1;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (timerZero) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (Stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stallCnt_q <= 16'd0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl - directed self-checking bench for md_ctrl with default latencies
// (MUL 5, DIV 10). Inputs change 1ns after a rising edge, outputs are sampled
// on the falling edge. "Cycle N" is the N-th clock period after a test's reset.
module tb_md_ctrl;

    logic        Clk;
    logic        Rst;
    logic        ReqValid;
    logic [3:0]  ReqOp;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic        Flush;
    logic [3:0]  MdOp;
    logic        MdStart;
    logic [31:0] MdA;
    logic [31:0] MdB;
    logic        Stall;
    logic        Busy;
    logic        MfValid;
    logic [15:0] StallCnt;

    int checks;
    int fails;

    md_ctrl dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .ReqValid (ReqValid),
        .ReqOp    (ReqOp),
        .ReqA     (ReqA),
        .ReqB     (ReqB),
        .Flush    (Flush),
        .MdOp     (MdOp),
        .MdStart  (MdStart),
        .MdA      (MdA),
        .MdB      (MdB),
        .Stall    (Stall),
        .Busy     (Busy),
        .MfValid  (MfValid),
        .StallCnt (StallCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic setReq(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic f);
        ReqValid = v;
        ReqOp    = op;
        ReqA     = a;
        ReqB     = b;
        Flush    = f;
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    // Leaves the bench 1ns into cycle 0 with Rst low and no request.
    task automatic doReset();
        Rst = 1'b1;
        setReq(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        nextCycle();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        setReq(1'b1, 4'd1, 32'd3, 32'd4, 1'b0);
        nextCycle();
        @(negedge Clk);
        checks++; if (MdStart !== 1'b0) begin fails++; $display("[TB] FAIL reset_mdstart got %b want 0", MdStart); end
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall got %b want 0", Stall); end
        checks++; if (MfValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_mfvalid got %b want 0", MfValid); end
        checks++; if (MdOp !== 4'd0) begin fails++; $display("[TB] FAIL reset_mdop got %0d want 0", MdOp); end
        nextCycle();
        Rst = 1'b0;
        setReq(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
        checks++; if (StallCnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_stallcnt got %0d want 0", StallCnt); end
    endtask

    task automatic test_mul_mflo();
        doReset();
        setReq(1'b1, 4'd1, 32'd3, 32'hFFFF_FFFC, 1'b0);
        @(negedge Clk);
        checks++; if (MdStart !== 1'b1) begin fails++; $display("[TB] FAIL mul_start got %b want 1", MdStart); end
        checks++; if (MdOp !== 4'd1) begin fails++; $display("[TB] FAIL mul_mdop got %0d want 1", MdOp); end
        checks++; if (MdA !== 32'd3) begin fails++; $display("[TB] FAIL mul_mda got %h want 3", MdA); end
        checks++; if (MdB !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL mul_mdb got %h want fffffffc", MdB); end
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL mul_busy_c0 got %b want 0", Busy); end
        nextCycle();
        setReq(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge Clk);
        checks++; if (Busy !== 1'b1) begin fails++; $display("[TB] FAIL mul_busy_c1 got %b want 1", Busy); end
        for (int c = 2; c <= 5; c++) begin
            nextCycle();
            setReq(1'b1, 4'd10, 32'd0, 32'd0, 1'b0);
            @(negedge Clk);
            checks++; if (Stall !== 1'b1) begin fails++; $display("[TB] FAIL mflo_stall c%0d got %b want 1", c, Stall); end
            checks++; if (MdOp !== 4'd0) begin fails++; $display("[TB] FAIL mflo_mdop c%0d got %0d want 0", c, MdOp); end
            checks++; if (MfValid !== 1'b0) begin fails++; $display("[TB] FAIL mflo_mfvalid c%0d got %b want 0", c, MfValid); end
            checks++; if (Busy !== 1'b1) begin fails++; $display("[TB] FAIL mflo_busy c%0d got %b want 1", c, Busy); end
        end
        nextCycle();
        @(negedge Clk);
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL mflo_stall_c6 got %b want 0", Stall); end
        checks++; if (MfValid !== 1'b1) begin fails++; $display("[TB] FAIL mflo_mfvalid_c6 got %b want 1", MfValid); end
        checks++; if (MdOp !== 4'd10) begin fails++; $display("[TB] FAIL mflo_mdop_c6 got %0d want 10", MdOp); end
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL mflo_busy_c6 got %b want 0", Busy); end
        checks++; if (StallCnt !== 16'd4) begin fails++; $display("[TB] FAIL mflo_stallcnt got %0d want 4", StallCnt); end
    endtask

    task automatic test_div_by_zero();
        doReset();
        setReq(1'b1, 4'd14, 32'd7, 32'd0, 1'b0);
        @(negedge Clk);
        checks++; if (MdStart !== 1'b0) begin fails++; $display("[TB] FAIL div0_start got %b want 0", MdStart); end
        checks++; if (MdOp !== 4'd14) begin fails++; $display("[TB] FAIL div0_mdop got %0d want 14", MdOp); end
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL div0_stall got %b want 0", Stall); end
        nextCycle();
        setReq(1'b1, 4'd9, 32'd0, 32'd0, 1'b0);
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL div0_busy got %b want 0", Busy); end
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL mfhi_stall got %b want 0", Stall); end
        checks++; if (MfValid !== 1'b1) begin fails++; $display("[TB] FAIL mfhi_mfvalid got %b want 1", MfValid); end
        checks++; if (MdStart !== 1'b0) begin fails++; $display("[TB] FAIL mfhi_start got %b want 0", MdStart); end
    endtask

    task automatic test_mthi_mtlo();
        doReset();
        setReq(1'b1, 4'd7, 32'd5, 32'd0, 1'b0);
        @(negedge Clk);
        checks++; if (MdOp !== 4'd7) begin fails++; $display("[TB] FAIL mthi_mdop got %0d want 7", MdOp); end
        checks++; if (MdStart !== 1'b0) begin fails++; $display("[TB] FAIL mthi_start got %b want 0", MdStart); end
        checks++; if (MfValid !== 1'b0) begin fails++; $display("[TB] FAIL mthi_mfvalid got %b want 0", MfValid); end
        nextCycle();
        setReq(1'b1, 4'd8, 32'd6, 32'd0, 1'b0);
        @(negedge Clk);
        checks++; if (MdOp !== 4'd8) begin fails++; $display("[TB] FAIL mtlo_mdop got %0d want 8", MdOp); end
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL mtlo_busy got %b want 0", Busy); end
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL mtlo_stall got %b want 0", Stall); end
    endtask

    task automatic test_back_to_back();
        doReset();
        setReq(1'b1, 4'd15, 32'd100, 32'd2, 1'b0);
        @(negedge Clk);
        checks++; if (MdStart !== 1'b1) begin fails++; $display("[TB] FAIL b2b_divstart got %b want 1", MdStart); end
        checks++; if (MdOp !== 4'd15) begin fails++; $display("[TB] FAIL b2b_divop got %0d want 15", MdOp); end
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            setReq(1'b1, 4'd1, 32'd3 + 32'(c), 32'd4, 1'b0);
            @(negedge Clk);
            checks++; if (Stall !== 1'b1) begin fails++; $display("[TB] FAIL b2b_stall c%0d got %b want 1", c, Stall); end
            checks++; if (MdStart !== 1'b0) begin fails++; $display("[TB] FAIL b2b_start c%0d got %b want 0", c, MdStart); end
            checks++; if (MdOp !== 4'd0) begin fails++; $display("[TB] FAIL b2b_mdop c%0d got %0d want 0", c, MdOp); end
            checks++; if (Busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_busy c%0d got %b want 1", c, Busy); end
            checks++; if (MdA !== 32'd3 + 32'(c)) begin fails++; $display("[TB] FAIL b2b_mda c%0d got %0d want %0d", c, MdA, 3 + c); end
        end
        nextCycle();
        setReq(1'b1, 4'd1, 32'd3, 32'd4, 1'b0);
        @(negedge Clk);
        checks++; if (MdStart !== 1'b1) begin fails++; $display("[TB] FAIL b2b_mulstart_c11 got %b want 1", MdStart); end
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL b2b_stall_c11 got %b want 0", Stall); end
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL b2b_busy_c11 got %b want 0", Busy); end
        checks++; if (StallCnt !== 16'd10) begin fails++; $display("[TB] FAIL b2b_stallcnt got %0d want 10", StallCnt); end
    endtask

    task automatic test_reset_mid_div();
        doReset();
        setReq(1'b1, 4'd14, 32'd9, 32'd5, 1'b0);
        @(negedge Clk);
        checks++; if (MdStart !== 1'b1) begin fails++; $display("[TB] FAIL rdiv_start got %b want 1", MdStart); end
        for (int c = 1; c <= 2; c++) begin
            nextCycle();
            setReq(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            @(negedge Clk);
            checks++; if (Busy !== 1'b1) begin fails++; $display("[TB] FAIL rdiv_busy c%0d got %b want 1", c, Busy); end
        end
        nextCycle();
        Rst = 1'b1;
        setReq(1'b1, 4'd1, 32'd1, 32'd1, 1'b0);
        @(negedge Clk);
        checks++; if (MdStart !== 1'b0) begin fails++; $display("[TB] FAIL rdiv_rst_start got %b want 0", MdStart); end
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL rdiv_rst_stall got %b want 0", Stall); end
        checks++; if (MdOp !== 4'd0) begin fails++; $display("[TB] FAIL rdiv_rst_mdop got %0d want 0", MdOp); end
        nextCycle();
        Rst = 1'b0;
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL rdiv_busy_c4 got %b want 0", Busy); end
        checks++; if (MdStart !== 1'b1) begin fails++; $display("[TB] FAIL rdiv_start_c4 got %b want 1", MdStart); end
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL rdiv_stall_c4 got %b want 0", Stall); end
        checks++; if (StallCnt !== 16'd0) begin fails++; $display("[TB] FAIL rdiv_stallcnt got %0d want 0", StallCnt); end
    endtask

    task automatic test_flush_and_illegal();
        doReset();
        setReq(1'b1, 4'd1, 32'd2, 32'd2, 1'b1);
        @(negedge Clk);
        checks++; if (MdStart !== 1'b0) begin fails++; $display("[TB] FAIL flush_start got %b want 0", MdStart); end
        checks++; if (MdOp !== 4'd0) begin fails++; $display("[TB] FAIL flush_mdop got %0d want 0", MdOp); end
        nextCycle();
        setReq(1'b1, 4'd11, 32'd2, 32'd2, 1'b0);
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_busy got %b want 0", Busy); end
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL op11_stall got %b want 0", Stall); end
        checks++; if (MdOp !== 4'd0) begin fails++; $display("[TB] FAIL op11_mdop got %0d want 0", MdOp); end
        checks++; if (MdStart !== 1'b0) begin fails++; $display("[TB] FAIL op11_start got %b want 0", MdStart); end
        checks++; if (MfValid !== 1'b0) begin fails++; $display("[TB] FAIL op11_mfvalid got %b want 0", MfValid); end
        // Start a multiply, then show illegal and flushed requests never stall
        // and a flush never cuts the operation short.
        nextCycle();
        setReq(1'b1, 4'd2, 32'd2, 32'd2, 1'b0);
        @(negedge Clk);
        checks++; if (MdStart !== 1'b1) begin fails++; $display("[TB] FAIL fl_mulstart got %b want 1", MdStart); end
        nextCycle();
        setReq(1'b1, 4'd12, 32'd0, 32'd0, 1'b0);
        @(negedge Clk);
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL op12_busy_stall got %b want 0", Stall); end
        nextCycle();
        setReq(1'b1, 4'd1, 32'd0, 32'd0, 1'b1);
        @(negedge Clk);
        checks++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL flush_busy_stall got %b want 0", Stall); end
        for (int c = 3; c <= 5; c++) begin
            nextCycle();
            setReq(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
            @(negedge Clk);
            checks++; if (Busy !== 1'b1) begin fails++; $display("[TB] FAIL fl_inflight c%0d got %b want 1", c, Busy); end
        end
        nextCycle();
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL fl_done_c6 got %b want 0", Busy); end
        checks++; if (StallCnt !== 16'd0) begin fails++; $display("[TB] FAIL fl_stallcnt got %0d want 0", StallCnt); end
    endtask

    // A DIVU held valid restarts every 11 cycles: 1 accept + 10 stalls.
    task automatic test_stallcnt_saturation();
        doReset();
        setReq(1'b1, 4'd15, 32'd1, 32'd1, 1'b0);
        repeat (11 * 6553) @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++; if (StallCnt !== 16'd65530) begin fails++; $display("[TB] FAIL sat_pre got %0d want 65530", StallCnt); end
        repeat (11 * 447) @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++; if (StallCnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_70000 got %h want ffff", StallCnt); end
        checks++; if (MdStart !== 1'b1) begin fails++; $display("[TB] FAIL sat_restart got %b want 1", MdStart); end
        repeat (2) nextCycle();
        @(negedge Clk);
        checks++; if (Stall !== 1'b1) begin fails++; $display("[TB] FAIL sat_stall got %b want 1", Stall); end
        checks++; if (StallCnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_hold got %h want ffff", StallCnt); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        Rst    = 1'b1;
        setReq(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_mul_mflo();
        test_div_by_zero();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid_div();
        test_flush_and_illegal();
        test_stallcnt_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, busy cycles after a multiply-family start.
REQ-002 SHALL have parameter DIV_LAT, default 10, busy cycles after a divide start.
REQ-003 SHALL have port Clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ReqValid  input  1  pipeline presents an MD-class instruction this cycle.
REQ-006 SHALL have port ReqOp  input  4  MD op code (1-6 mul family, 7 MTHI, 8 MTLO, 9 MFHI, 10 MFLO, 14 DIV, 15 DIVU).
REQ-007 SHALL have port ReqA  input  32  operand rs.
REQ-008 SHALL have port ReqB  input  32  operand rt.
REQ-009 SHALL have port Flush  input  1  cancel the presented request (exception/branch squash).
REQ-010 SHALL have port MdOp  output  4  op code driven to the MD unit.
REQ-011 SHALL have port MdStart  output  1  one-cycle start pulse to the MD unit.
REQ-012 SHALL have port MdA  output  32  operand A to the MD unit.
REQ-013 SHALL have port MdB  output  32  operand B to the MD unit.
REQ-014 SHALL have port Stall  output  1  freeze the issuing pipeline stage.
REQ-015 SHALL have port Busy  output  1  multiply/divide in flight.
REQ-016 SHALL have port MfValid  output  1  MFHI/MFLO accepted; unit result is valid this cycle.
REQ-017 SHALL have port StallCnt  output  16  saturating count of stall cycles.

Function
REQ-018 SHALL implement states IDLE, MUL, DIV with a down-counter cnt.
REQ-019 SHALL treat a request as "valid" when ReqValid=1, Flush=0 and ReqOp is in {1-10,14,15}; other codes are ignored (no stall, MdOp=0).
REQ-020 SHALL, in IDLE, accept any valid request in the same cycle: MdOp=ReqOp, MdA=ReqA, MdB=ReqB, Stall=0.
REQ-021 SHALL assert MdStart combinationally with acceptance of ops 1-6, load cnt=MUL_LAT and go to MUL.
REQ-022 SHALL assert MdStart with acceptance of ops 14/15 when ReqB!=0, load cnt=DIV_LAT and go to DIV.
REQ-023 SHALL, for ops 14/15 with ReqB==0, accept with MdStart=0 and remain IDLE; HI/LO unchanged.
REQ-024 SHALL accept ops 7/8 in IDLE with MdStart=0 and remain IDLE (unit writes HI/LO that edge).
REQ-025 SHALL accept ops 9/10 in IDLE with MfValid=1, MdStart=0, remaining IDLE.
REQ-026 SHALL, in MUL or DIV, assert Stall=1 for any valid request and drive MdOp=0, MdStart=0, MfValid=0.
REQ-027 SHALL decrement cnt each cycle in MUL/DIV and return to IDLE on the edge where cnt goes 1->0.
REQ-028 SHALL give Busy=1 exactly when state != IDLE; start at edge t yields Busy high for cycles t+1..t+LAT, first acceptance at cycle t+LAT+1.
REQ-029 SHALL NOT abort an in-flight operation on Flush; Flush only suppresses the presented request.
REQ-030 SHALL drive MdA/MdB=ReqA/ReqB at all times (unit ignores them without MdOp/MdStart).
REQ-031 SHALL increment StallCnt each cycle Stall=1, saturating at 16'hFFFF.

Reset
REQ-032 SHALL on Rst=1 at a rising edge set state=IDLE, cnt=0, StallCnt=0, including mid-operation.
REQ-033 SHALL, while Rst=1, force MdStart=0, Stall=0, MfValid=0, MdOp=0; Busy=0 the cycle after reset.
REQ-034 SHALL share Rst with the MD unit so both clear HI/LO/busy on the same edge.

Structure
REQ-035 SHALL place op-code constants, MUL_LAT/DIV_LAT defaults and the state encoding in a shared package md_pkg.
REQ-036 SHALL implement cnt as sub-module md_busy_timer (load value, load strobe, decrement, zero flag).

Verification
REQ-037 SHALL test: op 1, A=3, B=-4 at cycle 0 -> MdStart=1 cycle 0, Busy cycles 1-5, MFLO at cycle 2 stalls until cycle 6, MfValid=1 at cycle 6.
REQ-038 SHALL test: op 14, A=7, B=0 -> MdStart=0, Busy=0, following MFHI accepted next cycle without stall.
REQ-039 SHALL test: op 15, B=2 followed by back-to-back op 1 -> Stall=1 for 10 cycles, second MdStart exactly at cycle 11, StallCnt=10.
REQ-040 SHALL test: Rst asserted at cycle 3 of a DIV -> Busy=0 from cycle 4, new op 1 accepted at cycle 4 with MdStart=1.
REQ-041 SHALL test: ReqValid=1, op 1 with Flush=1 in IDLE -> MdStart=0, Busy stays 0; op 11 -> no stall, MdOp=0.
REQ-042 SHALL test: 70000 consecutive stall cycles -> StallCnt holds 16'hFFFF.
